// File: rtl/vpd_access_controller_if.sv
// Storage-port bundle between the VPD access controller and the dword-wide VPD backing store.
interface vpd_access_controller_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-3:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/vpd_access_controller.sv
// PCIe VPD capability sequencer: turns an Address-register write into one store read or write,
// then toggles the F flag to tell software the access has finished (or timed out).
module vpd_access_controller #(
    parameter int ADDR_WIDTH     = 15,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_addr_we,
    input  logic [1:0]             cfg_addr_be,
    input  logic [15:0]            cfg_addr_wdata,
    input  logic                   cfg_data_we,
    input  logic [3:0]             cfg_data_be,
    input  logic [DATA_WIDTH-1:0]  cfg_data_wdata,
    output logic [15:0]            vpd_addr_reg,
    output logic [DATA_WIDTH-1:0]  vpd_data_reg,
    vpd_access_controller_if.master mem,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             mem_we_q;
    logic             addr_accept;
    logic             data_accept;
    logic             rd_complete;
    logic             timeout_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Only full-width writes are taken, and only while no access is outstanding.
    always_comb begin
        state_next  = state;
        addr_accept = 1'b0;
        data_accept = 1'b0;
        rd_complete = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                addr_accept = cfg_addr_we && (cfg_addr_be == 2'b11);
                data_accept = cfg_data_we && (cfg_data_be == 4'b1111);
                if (addr_accept) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    rd_complete = !mem_we_q;
                    state_next  = DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vpd_addr_reg <= '0;
            vpd_data_reg <= '0;
            mem_we_q     <= 1'b0;
            timeout_err  <= 1'b0;
            cnt          <= '0;
        end else begin
            if (data_accept) begin
                vpd_data_reg <= cfg_data_wdata;
            end else if (rd_complete) begin
                vpd_data_reg <= mem.mem_rdata;
            end

            if (addr_accept) begin
                vpd_addr_reg <= cfg_addr_wdata;
                mem_we_q     <= cfg_addr_wdata[15];
                timeout_err  <= 1'b0;
            end else if (timeout_hit) begin
                timeout_err  <= 1'b1;
            end

            // F flips only on leaving DONE, so a reset mid-access never shows a half-finished flag.
            if (state == DONE) begin
                vpd_addr_reg[15] <= ~vpd_addr_reg[15];
            end

            if (state == REQ) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    assign busy          = (state != IDLE);
    assign mem.mem_req   = (state == REQ);
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = vpd_addr_reg[ADDR_WIDTH-1:2];
    assign mem.mem_wdata = vpd_data_reg;

endmodule

// File: tb/tb_vpd_access_controller.sv
// Directed-vector bench for vpd_access_controller with a short timeout so abort paths are quick to reach.
module tb_vpd_access_controller;

    localparam int AW = 15;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk;
    logic          rst;
    logic          cfg_addr_we;
    logic [1:0]    cfg_addr_be;
    logic [15:0]   cfg_addr_wdata;
    logic          cfg_data_we;
    logic [3:0]    cfg_data_be;
    logic [DW-1:0] cfg_data_wdata;
    logic [15:0]   vpd_addr_reg;
    logic [DW-1:0] vpd_data_reg;
    logic          busy;
    logic          timeout_err;

    logic [DW-1:0] store [0:8191];
    int n_cmp;
    int n_fail;

    vpd_access_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mif ();

    vpd_access_controller #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_addr_we(cfg_addr_we),
        .cfg_addr_be(cfg_addr_be),
        .cfg_addr_wdata(cfg_addr_wdata),
        .cfg_data_we(cfg_data_we),
        .cfg_data_be(cfg_data_be),
        .cfg_data_wdata(cfg_data_wdata),
        .vpd_addr_reg(vpd_addr_reg),
        .vpd_data_reg(vpd_data_reg),
        .mem(mif),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_write(input logic [15:0] v, input logic [1:0] be);
        cfg_addr_we = 1'b1; cfg_addr_be = be; cfg_addr_wdata = v;
        tick();
        cfg_addr_we = 1'b0; cfg_addr_be = 2'b00; cfg_addr_wdata = 16'h0;
    endtask

    task automatic data_write(input logic [DW-1:0] v, input logic [3:0] be);
        cfg_data_we = 1'b1; cfg_data_be = be; cfg_data_wdata = v;
        tick();
        cfg_data_we = 1'b0; cfg_data_be = 4'h0; cfg_data_wdata = '0;
    endtask

    task automatic ack_once(input logic [DW-1:0] rdata);
        mif.mem_ack = 1'b1; mif.mem_rdata = rdata;
        tick();
        mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++; if (vpd_addr_reg !== 16'h0000) begin n_fail++; $display("[TB] FAIL rst_addr got %h want %h", vpd_addr_reg, 16'h0000); end
        n_cmp++; if (vpd_data_reg !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_data got %h want %h", vpd_data_reg, 32'h0); end
        n_cmp++; if (mif.mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_req got %b want 0", mif.mem_req); end
        n_cmp++; if (mif.mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_we got %b want 0", mif.mem_we); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_terr got %b want 0", timeout_err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read();
        store[13'h10] = 32'hDEADBEEF;
        addr_write(16'h0040, 2'b11);
        n_cmp++; if (mif.mem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_req got %b want 1", mif.mem_req); end
        n_cmp++; if (mif.mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_we got %b want 0", mif.mem_we); end
        n_cmp++; if (mif.mem_addr !== 13'h10) begin n_fail++; $display("[TB] FAIL rd_maddr got %h want %h", mif.mem_addr, 13'h10); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_busy got %b want 1", busy); end
        tick(); tick();
        ack_once(store[mif.mem_addr]);
        n_cmp++; if (mif.mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_req_drop got %b want 0", mif.mem_req); end
        n_cmp++; if (vpd_data_reg !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL rd_data got %h want %h", vpd_data_reg, 32'hDEADBEEF); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_busy_done got %b want 1", busy); end
        n_cmp++; if (vpd_addr_reg !== 16'h0040) begin n_fail++; $display("[TB] FAIL rd_f_early got %h want %h", vpd_addr_reg, 16'h0040); end
        tick();
        n_cmp++; if (vpd_addr_reg !== 16'h8040) begin n_fail++; $display("[TB] FAIL rd_f_done got %h want %h", vpd_addr_reg, 16'h8040); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_busy_end got %b want 0", busy); end
    endtask

    task automatic test_write();
        data_write(32'h12345678, 4'b1111);
        n_cmp++; if (vpd_data_reg !== 32'h12345678) begin n_fail++; $display("[TB] FAIL wr_dreg got %h want %h", vpd_data_reg, 32'h12345678); end
        addr_write(16'h8044, 2'b11);
        n_cmp++; if (mif.mem_we !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_we got %b want 1", mif.mem_we); end
        n_cmp++; if (mif.mem_addr !== 13'h11) begin n_fail++; $display("[TB] FAIL wr_maddr got %h want %h", mif.mem_addr, 13'h11); end
        n_cmp++; if (mif.mem_wdata !== 32'h12345678) begin n_fail++; $display("[TB] FAIL wr_wdata got %h want %h", mif.mem_wdata, 32'h12345678); end
        ack_once(32'hFFFF0000);
        n_cmp++; if (mif.mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_req_drop got %b want 0", mif.mem_req); end
        tick();
        n_cmp++; if (vpd_addr_reg !== 16'h0044) begin n_fail++; $display("[TB] FAIL wr_f_done got %h want %h", vpd_addr_reg, 16'h0044); end
        n_cmp++; if (vpd_data_reg !== 32'h12345678) begin n_fail++; $display("[TB] FAIL wr_dkeep got %h want %h", vpd_data_reg, 32'h12345678); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_busy_end got %b want 0", busy); end
    endtask

    task automatic test_protection();
        data_write(32'h0BADF00D, 4'b0111);
        n_cmp++; if (vpd_data_reg !== 32'h12345678) begin n_fail++; $display("[TB] FAIL pr_partial_data got %h want %h", vpd_data_reg, 32'h12345678); end
        addr_write(16'h0100, 2'b01);
        n_cmp++; if (vpd_addr_reg !== 16'h0044) begin n_fail++; $display("[TB] FAIL pr_partial_addr got %h want %h", vpd_addr_reg, 16'h0044); end
        n_cmp++; if (mif.mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL pr_partial_req got %b want 0", mif.mem_req); end
        ack_once(32'h77777777);
        n_cmp++; if (vpd_data_reg !== 32'h12345678) begin n_fail++; $display("[TB] FAIL pr_idle_ack got %h want %h", vpd_data_reg, 32'h12345678); end
        addr_write(16'h0020, 2'b11);
        data_write(32'hCAFEBABE, 4'b1111);
        addr_write(16'h8030, 2'b11);
        n_cmp++; if (vpd_addr_reg !== 16'h0020) begin n_fail++; $display("[TB] FAIL pr_busy_addr got %h want %h", vpd_addr_reg, 16'h0020); end
        n_cmp++; if (vpd_data_reg !== 32'h12345678) begin n_fail++; $display("[TB] FAIL pr_busy_data got %h want %h", vpd_data_reg, 32'h12345678); end
        n_cmp++; if (mif.mem_addr !== 13'h8) begin n_fail++; $display("[TB] FAIL pr_busy_maddr got %h want %h", mif.mem_addr, 13'h8); end
        n_cmp++; if (mif.mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL pr_busy_we got %b want 0", mif.mem_we); end
        n_cmp++; if (mif.mem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL pr_busy_req got %b want 1", mif.mem_req); end
        ack_once(32'h00C0FFEE);
        tick();
        n_cmp++; if (vpd_data_reg !== 32'h00C0FFEE) begin n_fail++; $display("[TB] FAIL pr_rd_data got %h want %h", vpd_data_reg, 32'h00C0FFEE); end
        n_cmp++; if (vpd_addr_reg !== 16'h8020) begin n_fail++; $display("[TB] FAIL pr_rd_f got %h want %h", vpd_addr_reg, 16'h8020); end
    endtask

    task automatic test_timeout();
        int req_cycles;
        req_cycles = 0;
        addr_write(16'h0008, 2'b11);
        for (int i = 0; i < 20; i++) begin
            if (mif.mem_req !== 1'b1) break;
            req_cycles++;
            tick();
        end
        n_cmp++; if (req_cycles !== TO) begin n_fail++; $display("[TB] FAIL to_req_cycles got %0d want %0d", req_cycles, TO); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_fail++; $display("[TB] FAIL to_err got %b want 1", timeout_err); end
        n_cmp++; if (vpd_data_reg !== 32'h00C0FFEE) begin n_fail++; $display("[TB] FAIL to_data got %h want %h", vpd_data_reg, 32'h00C0FFEE); end
        tick();
        n_cmp++; if (vpd_addr_reg !== 16'h8008) begin n_fail++; $display("[TB] FAIL to_f got %h want %h", vpd_addr_reg, 16'h8008); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL to_busy got %b want 0", busy); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_fail++; $display("[TB] FAIL to_sticky got %b want 1", timeout_err); end
    endtask

    task automatic test_collision();
        cfg_data_we = 1'b1; cfg_data_be = 4'b1111; cfg_data_wdata = 32'hA5A5A5A5;
        cfg_addr_we = 1'b1; cfg_addr_be = 2'b11;   cfg_addr_wdata = 16'h8000;
        tick();
        cfg_data_we = 1'b0; cfg_data_be = 4'h0; cfg_data_wdata = '0;
        cfg_addr_we = 1'b0; cfg_addr_be = 2'b00; cfg_addr_wdata = 16'h0;
        n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("[TB] FAIL co_err_clear got %b want 0", timeout_err); end
        n_cmp++; if (mif.mem_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("[TB] FAIL co_wdata got %h want %h", mif.mem_wdata, 32'hA5A5A5A5); end
        n_cmp++; if (mif.mem_we !== 1'b1) begin n_fail++; $display("[TB] FAIL co_we got %b want 1", mif.mem_we); end
        repeat (TO - 1) tick();
        n_cmp++; if (mif.mem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL co_req_last got %b want 1", mif.mem_req); end
        ack_once(32'h0);
        n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("[TB] FAIL co_ack_wins got %b want 0", timeout_err); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL co_busy_done got %b want 1", busy); end
        tick();
        n_cmp++; if (vpd_addr_reg !== 16'h0000) begin n_fail++; $display("[TB] FAIL co_f got %h want %h", vpd_addr_reg, 16'h0000); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL co_busy_end got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_req();
        addr_write(16'h0050, 2'b11);
        n_cmp++; if (mif.mem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL rm_req_pre got %b want 1", mif.mem_req); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (mif.mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_req got %b want 0", mif.mem_req); end
        n_cmp++; if (vpd_addr_reg !== 16'h0000) begin n_fail++; $display("[TB] FAIL rm_addr got %h want %h", vpd_addr_reg, 16'h0000); end
        n_cmp++; if (vpd_data_reg !== 32'h0) begin n_fail++; $display("[TB] FAIL rm_data got %h want %h", vpd_data_reg, 32'h0); end
        ack_once(32'hFFFFFFFF);
        tick();
        n_cmp++; if (vpd_data_reg !== 32'h0) begin n_fail++; $display("[TB] FAIL rm_late_ack got %h want %h", vpd_data_reg, 32'h0); end
        n_cmp++; if (vpd_addr_reg !== 16'h0000) begin n_fail++; $display("[TB] FAIL rm_late_f got %h want %h", vpd_addr_reg, 16'h0000); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_busy got %b want 0", busy); end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        cfg_addr_we = 1'b0; cfg_addr_be = 2'b00; cfg_addr_wdata = 16'h0;
        cfg_data_we = 1'b0; cfg_data_be = 4'h0;  cfg_data_wdata = '0;
        mif.mem_ack = 1'b0; mif.mem_rdata = '0;
        for (int i = 0; i < 8192; i++) store[i] = '0;

        test_reset();
        test_read();
        test_write();
        test_protection();
        test_timeout();
        test_collision();
        test_reset_mid_req();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
